// File: rtl/fpu_sequencer.sv
// Request sequencer for the Q16.48 processing unit: one operation in flight,
// valid/ready request and response channels, divider busy tracking with timeout.
module fpu_sequencer #(
   parameter int TAG_W       = 4,
   parameter int DIV_TIMEOUT = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [63:0]      req_a,
   input  logic [63:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_res,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_nan,
   output logic             rsp_inf,
   output logic             rsp_timeout,
   output logic [3:0]       fpu_op,
   output logic [63:0]      fpu_a,
   output logic [63:0]      fpu_b,
   input  logic             fpu_busy,
   input  logic [63:0]      fpu_res
);

   localparam int              CNT_W     = $clog2(DIV_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DIV_TIMEOUT);
   localparam logic [3:0]      OP_NOP    = 4'b0000;
   localparam logic [3:0]      OP_DIV    = 4'b0011;
   localparam logic [63:0]     RES_NAN   = 64'h8000_0000_0000_0000;
   localparam logic [63:0]     RES_PINF  = 64'h7fff_ffff_ffff_ffff;
   localparam logic [63:0]     RES_NINF  = 64'h8000_0000_0000_0001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DIV_LAUNCH,
      S_DIV_WAIT,
      S_RESP
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [63:0]        a_q, a_d;
   logic [63:0]        b_q, b_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [63:0]        res_q, res_d;
   logic               tmo_q, tmo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               illegal_op;

   assign illegal_op = (req_op == 4'b0111) || (req_op == 4'b1011) ||
                       (req_op == 4'b1110) || (req_op == 4'b1111);

   always_comb begin
      // NOTE: every output and next-state value gets a default before the case,
      // so no path through the case can leave one unassigned and infer a latch.
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      tag_d     = tag_q;
      res_d     = res_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      fpu_op    = OP_NOP;

      unique case (state_q)
         S_IDLE: begin
            req_ready = !fpu_busy;
            if (req_valid && !fpu_busy) begin
               op_d  = req_op;
               a_d   = req_a;
               b_d   = req_b;
               tag_d = req_tag;
               tmo_d = 1'b0;
               if (illegal_op) begin
                  res_d   = RES_NAN;
                  state_d = S_RESP;
               end else if (req_op == OP_DIV) begin
                  state_d = S_DIV_LAUNCH;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            fpu_op  = op_q;
            res_d   = fpu_res;
            state_d = S_RESP;
         end
         S_DIV_LAUNCH: begin
            fpu_op  = OP_DIV;
            cnt_d   = '0;
            state_d = S_DIV_WAIT;
         end
         S_DIV_WAIT: begin
            // The divide opcode stays applied here, so the cycle busy drops also relaunches the unit.
            fpu_op = OP_DIV;
            cnt_d  = cnt_q + CNT_W'(1);
            if (!fpu_busy) begin
               res_d   = fpu_res;
               state_d = S_RESP;
            end else if (cnt_d == CNT_LIMIT) begin
               res_d   = RES_NAN;
               tmo_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               tmo_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         tag_q   <= '0;
         res_q   <= '0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_res     = res_q;
   assign rsp_tag     = tag_q;
   assign rsp_timeout = tmo_q;
   assign rsp_nan     = (res_q == RES_NAN);
   assign rsp_inf     = (res_q == RES_PINF) || (res_q == RES_NINF);
   assign fpu_a       = a_q;
   assign fpu_b       = b_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: a behavioural unit model with a 40-cycle
// divider drives the main instance; a second instance sees a stuck divider.
module tb_fpu_sequencer;

   localparam logic [63:0] Q_ONE   = 64'h0001_0000_0000_0000;
   localparam logic [63:0] Q_TWO   = 64'h0002_0000_0000_0000;
   localparam logic [63:0] Q_THREE = 64'h0003_0000_0000_0000;
   localparam logic [63:0] Q_FOUR  = 64'h0004_0000_0000_0000;
   localparam logic [63:0] Q_SIX   = 64'h0006_0000_0000_0000;
   localparam logic [63:0] Q_NAN   = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'h0;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic [3:0]  req_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_res;
   logic [3:0]  rsp_tag;
   logic        rsp_nan, rsp_inf, rsp_timeout;
   logic [3:0]  fpu_op;
   logic [63:0] fpu_a, fpu_b;
   logic        fpu_busy;
   logic [63:0] fpu_res;

   logic        req_valid2 = 1'b0;
   logic        req_ready2;
   logic        rsp_valid2;
   logic        rsp_ready2 = 1'b0;
   logic [63:0] rsp_res2;
   logic [3:0]  rsp_tag2;
   logic        rsp_nan2, rsp_inf2, rsp_timeout2;
   logic [3:0]  fpu_op2;
   logic [63:0] fpu_a2, fpu_b2;
   logic        fpu_busy2 = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpu_sequencer #(.TAG_W(4), .DIV_TIMEOUT(128)) u_dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
      .rsp_tag(rsp_tag), .rsp_nan(rsp_nan), .rsp_inf(rsp_inf),
      .rsp_timeout(rsp_timeout),
      .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_busy(fpu_busy), .fpu_res(fpu_res)
   );

   fpu_sequencer #(.TAG_W(4), .DIV_TIMEOUT(8)) u_dut_to (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_res(rsp_res2),
      .rsp_tag(rsp_tag2), .rsp_nan(rsp_nan2), .rsp_inf(rsp_inf2),
      .rsp_timeout(rsp_timeout2),
      .fpu_op(fpu_op2), .fpu_a(fpu_a2), .fpu_b(fpu_b2),
      .fpu_busy(fpu_busy2), .fpu_res(64'h0)
   );

   // Unit model: add, multiply, divide in Q16.48; a divide opcode seen while
   // idle starts a 40-cycle busy window.
   logic signed [127:0] a_ext, b_ext, prod, quot;
   logic [5:0]          busy_cnt;

   assign a_ext = {{64{fpu_a[63]}}, fpu_a};
   assign b_ext = {{64{fpu_b[63]}}, fpu_b};
   assign prod  = a_ext * b_ext;
   assign quot  = (b_ext == 128'sd0) ? 128'sd0 : (a_ext <<< 48) / b_ext;
   assign fpu_busy = (busy_cnt != 6'd0);

   always_comb begin
      fpu_res = 64'h0;
      case (fpu_op)
         4'h0:    fpu_res = fpu_a + fpu_b;
         4'h2:    fpu_res = prod[111:48];
         4'h3:    fpu_res = quot[63:0];
         default: fpu_res = 64'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                busy_cnt <= 6'd0;
      else if (busy_cnt != 6'd0) busy_cnt <= busy_cnt - 6'd1;
      else if (fpu_op == 4'h3)   busy_cnt <= 6'd40;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request to the main instance and returns just after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag);
      int n;
      req_op = op; req_a = a; req_b = b; req_tag = tag;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("req_ready_before_send", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      logic bad;
      logic [63:0] held_res;

      #1_000_000;
      $display("FAIL watchdog expired before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic bad;
      logic [63:0] held_res;

      // Reset values
      #3;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_res", rsp_res, 64'h0);
      check("rst_fpu_op", 64'(fpu_op), 64'd0);
      check("rst_fpu_a", fpu_a, 64'h0);
      check("rst_flags", 64'({rsp_nan, rsp_inf, rsp_timeout}), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_req_ready", 64'(req_ready), 64'd1);

      // Add 1.0 + 2.0, tag 3
      send(4'h0, Q_ONE, Q_TWO, 4'd3);
      check("add_n1_rsp_valid", 64'(rsp_valid), 64'd0);
      check("add_n1_req_ready", 64'(req_ready), 64'd0);
      check("add_n1_fpu_a", fpu_a, Q_ONE);
      check("add_n1_fpu_b", fpu_b, Q_TWO);
      tick();
      check("add_n2_rsp_valid", 64'(rsp_valid), 64'd1);
      check("add_res", rsp_res, Q_THREE);
      check("add_tag", 64'(rsp_tag), 64'd3);
      check("add_fpu_op", 64'(fpu_op), 64'd0);
      check("add_flags", 64'({rsp_nan, rsp_inf, rsp_timeout}), 64'd0);
      consume();
      check("add_done_rsp_valid", 64'(rsp_valid), 64'd0);
      check("add_done_req_ready", 64'(req_ready), 64'd1);

      // Multiply 2.0 * 3.0 under 10 cycles of backpressure
      send(4'h2, Q_TWO, Q_THREE, 4'd9);
      check("mul_issue_fpu_op", 64'(fpu_op), 64'd2);
      tick();
      check("mul_rsp_valid", 64'(rsp_valid), 64'd1);
      check("mul_res", rsp_res, Q_SIX);
      held_res = rsp_res;
      req_op = 4'h0; req_a = Q_ONE; req_b = Q_ONE; req_tag = 4'd1;
      req_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid !== 1'b1 || rsp_res !== held_res || rsp_tag !== 4'd9 ||
             req_ready !== 1'b0 || fpu_op !== 4'h0)
            bad = 1'b1;
         tick();
      end
      check("bp_stable", 64'(bad), 64'd0);
      check("bp_still_valid", 64'(rsp_valid), 64'd1);
      req_valid = 1'b0;
      consume();
      check("bp_done_rsp_valid", 64'(rsp_valid), 64'd0);
      check("bp_no_extra_accept", 64'(req_ready), 64'd1);

      // Illegal opcode 1110, tag 7
      send(4'hE, Q_ONE, Q_ONE, 4'd7);
      n = 1;
      bad = (fpu_op !== 4'h0);
      while (rsp_valid !== 1'b1 && n < 5) begin
         tick();
         n++;
         if (fpu_op !== 4'h0) bad = 1'b1;
      end
      check("ill_latency_in_range", 64'(n >= 1 && n <= 2), 64'd1);
      check("ill_rsp_valid", 64'(rsp_valid), 64'd1);
      check("ill_res", rsp_res, Q_NAN);
      check("ill_nan", 64'(rsp_nan), 64'd1);
      check("ill_inf_tmo", 64'({rsp_inf, rsp_timeout}), 64'd0);
      check("ill_tag", 64'(rsp_tag), 64'd7);
      check("ill_fpu_op_idle", 64'(bad), 64'd0);
      consume();
      check("ill_done_rsp_valid", 64'(rsp_valid), 64'd0);

      // Divide 6.0 / 2.0 with a 40-cycle busy window
      send(4'h3, Q_SIX, Q_TWO, 4'd4);
      check("div_launch_fpu_op", 64'(fpu_op), 64'd3);
      n = 0;
      bad = 1'b0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         if (fpu_op !== 4'h3) bad = 1'b1;
         tick();
         n++;
      end
      check("div_cycles_after_accept", 64'(n), 64'd42);
      check("div_fpu_op_held", 64'(bad), 64'd0);
      check("div_res", rsp_res, Q_THREE);
      check("div_tag", 64'(rsp_tag), 64'd4);
      check("div_timeout", 64'(rsp_timeout), 64'd0);
      check("div_rsp_fpu_op", 64'(fpu_op), 64'd0);
      consume();
      check("div_relaunch_busy", 64'(fpu_busy), 64'd1);
      check("div_relaunch_blocks_ready", 64'(req_ready), 64'd0);
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("div_ready_after_relaunch", 64'(req_ready), 64'd1);

      // Timeout: second instance, DIV_TIMEOUT = 8, busy stuck high after launch
      req_op = 4'h3; req_a = Q_SIX; req_b = Q_TWO; req_tag = 4'd12;
      check("to_req_ready", 64'(req_ready2), 64'd1);
      req_valid2 = 1'b1;
      tick();
      req_valid2 = 1'b0;
      fpu_busy2 = 1'b1;
      check("to_launch_fpu_op", 64'(fpu_op2), 64'd3);
      n = 0;
      while (rsp_valid2 !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("to_cycles_after_accept", 64'(n), 64'd9);
      check("to_timeout", 64'(rsp_timeout2), 64'd1);
      check("to_nan", 64'(rsp_nan2), 64'd1);
      check("to_res", rsp_res2, Q_NAN);
      check("to_inf", 64'(rsp_inf2), 64'd0);
      check("to_tag", 64'(rsp_tag2), 64'd12);
      rsp_ready2 = 1'b1;
      tick();
      rsp_ready2 = 1'b0;
      check("to_done_valid", 64'(rsp_valid2), 64'd0);
      check("to_done_timeout_clear", 64'(rsp_timeout2), 64'd0);

      // Reset asserted mid-divide
      send(4'h3, Q_SIX, Q_TWO, 4'd2);
      for (int i = 0; i < 5; i++) tick();
      check("rst_mid_in_wait", 64'(fpu_op), 64'd3);
      #2;
      rst_n = 1'b0;
      req_op = 4'h0; req_a = Q_ONE; req_b = Q_TWO; req_tag = 4'd6;
      req_valid = 1'b1;
      #1;
      check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("async_rst_fpu_op", 64'(fpu_op), 64'd0);
      check("async_rst_fpu_a", fpu_a, 64'h0);
      check("async_rst_fpu_b", fpu_b, 64'h0);
      check("async_rst_tag", 64'(rsp_tag), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      req_valid = 1'b0;
      tick();
      check("rst_req_ignored_valid", 64'(rsp_valid), 64'd0);
      check("rst_req_ignored_a", fpu_a, 64'h0);
      send(4'h2, Q_TWO, Q_TWO, 4'd5);
      tick();
      check("post_rst_mul_valid", 64'(rsp_valid), 64'd1);
      check("post_rst_mul_res", rsp_res, Q_FOUR);
      check("post_rst_mul_tag", 64'(rsp_tag), 64'd5);
      consume();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
